safe_countdown_timer: RTL and testbench

Registered mm:ss countdown timer for the electronic safe's lockout/open window. It holds a BCD minutes:seconds value, decrements it once per prescaled second while running, and flags expiry. Its four 4-bit digit outputs feed the per-digit hex-to-seven-segment converters directly, one nibble per display.

---
 rtl/safe_countdown_timer.sv | 130 +++++++++++++
 tb/tb_safe_countdown_timer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/safe_countdown_timer.sv
// BCD mm:ss countdown timer: load/start/pause strobes, one decrement per TICK_DIV cycles in RUN.
// All outputs registered; strobes take effect on the next clk edge.
module safe_countdown_timer #(
   parameter int TICK_DIV = 50_000_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [15:0] load_value,
   input  logic        start,
   input  logic        pause,
   output logic [3:0]  min_tens,
   output logic [3:0]  min_ones,
   output logic [3:0]  sec_tens,
   output logic [3:0]  sec_ones,
   output logic        running,
   output logic        expired
);

   localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] presc, presc_nxt;
   logic [3:0]    mt_nxt, mo_nxt, st_nxt, so_nxt;
   logic [3:0]    dec_mt, dec_mo, dec_st, dec_so;
   logic          value_zero, dec_zero, tick;

   function automatic logic [3:0] clamp(input logic [3:0] d, input logic [3:0] lim);
      return (d > lim) ? lim : d;
   endfunction

   assign value_zero = ({min_tens, min_ones, sec_tens, sec_ones} == 16'h0000);
   assign tick       = (presc == CW'(TICK_DIV - 1));

   // BCD borrow chain; only used in RUN, where the value is never 00:00
   always_comb begin
      dec_mt = min_tens;
      dec_mo = min_ones;
      dec_st = sec_tens;
      dec_so = sec_ones;
      if (sec_ones != 4'd0) begin
         dec_so = sec_ones - 4'd1;
      end else begin
         dec_so = 4'd9;
         if (sec_tens != 4'd0) begin
            dec_st = sec_tens - 4'd1;
         end else begin
            dec_st = 4'd5;
            if (min_ones != 4'd0) begin
               dec_mo = min_ones - 4'd1;
            end else begin
               dec_mo = 4'd9;
               if (min_tens != 4'd0) dec_mt = min_tens - 4'd1;
            end
         end
      end
   end

   assign dec_zero = ({dec_mt, dec_mo, dec_st, dec_so} == 16'h0000);

   always_comb begin
      state_nxt = state;
      presc_nxt = presc;
      mt_nxt    = min_tens;
      mo_nxt    = min_ones;
      st_nxt    = sec_tens;
      so_nxt    = sec_ones;
      if (load) begin
         state_nxt = IDLE;
         presc_nxt = '0;
         mt_nxt    = clamp(load_value[15:12], 4'd9);
         mo_nxt    = clamp(load_value[11:8],  4'd9);
         st_nxt    = clamp(load_value[7:4],   4'd5);
         so_nxt    = clamp(load_value[3:0],   4'd9);
      end else begin
         case (state)
            IDLE: begin
               if (start && !value_zero) begin
                  state_nxt = RUN;
                  presc_nxt = '0;
               end
            end
            PAUSED: begin
               if (start && !value_zero) state_nxt = RUN;
            end
            RUN: begin
               // pause wins over a coincident start and over a coincident tick
               if (pause) begin
                  state_nxt = PAUSED;
               end else if (tick) begin
                  presc_nxt = '0;
                  mt_nxt    = dec_mt;
                  mo_nxt    = dec_mo;
                  st_nxt    = dec_st;
                  so_nxt    = dec_so;
                  if (dec_zero) state_nxt = EXPIRED;
               end else begin
                  presc_nxt = presc + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         presc    <= '0;
         min_tens <= 4'd0;
         min_ones <= 4'd0;
         sec_tens <= 4'd0;
         sec_ones <= 4'd0;
         running  <= 1'b0;
         expired  <= 1'b0;
      end else begin
         state    <= state_nxt;
         presc    <= presc_nxt;
         min_tens <= mt_nxt;
         min_ones <= mo_nxt;
         sec_tens <= st_nxt;
         sec_ones <= so_nxt;
         running  <= (state_nxt == RUN);
         expired  <= (state_nxt == EXPIRED);
      end
   end

endmodule

// File: tb/tb_safe_countdown_timer.sv
// Directed bench for safe_countdown_timer with TICK_DIV=4.
module tb_safe_countdown_timer;

   logic        clk;
   logic        reset;
   logic        load;
   logic [15:0] load_value;
   logic        start;
   logic        pause;
   logic [3:0]  min_tens, min_ones, sec_tens, sec_ones;
   logic        running, expired;
   logic [15:0] disp;

   int checks = 0;
   int errors = 0;

   safe_countdown_timer #(.TICK_DIV(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .load_value (load_value),
      .start      (start),
      .pause      (pause),
      .min_tens   (min_tens),
      .min_ones   (min_ones),
      .sec_tens   (sec_tens),
      .sec_ones   (sec_ones),
      .running    (running),
      .expired    (expired)
   );

   assign disp = {min_tens, min_ones, sec_tens, sec_ones};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_load(input logic [15:0] v);
      load = 1'b1;
      load_value = v;
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic pulse(input logic s, input logic p);
      start = s;
      pause = p;
      @(negedge clk);
      start = 1'b0;
      pause = 1'b0;
   endtask

   initial begin
      reset = 1'b1; load = 1'b0; load_value = 16'h0000; start = 1'b0; pause = 1'b0;
      step(2);
      reset = 1'b0;
      check("reset_digits", disp, 16'h0000);
      check("reset_running", {15'd0, running}, 16'd0);
      check("reset_expired", {15'd0, expired}, 16'd0);

      // countdown with sec_tens and min_ones borrow
      do_load(16'h0102);
      check("load_0102", disp, 16'h0102);
      check("load_idle", {15'd0, running}, 16'd0);
      pulse(1'b1, 1'b0);
      check("start_running", {15'd0, running}, 16'd1);
      step(3);
      check("pre_tick", disp, 16'h0102);
      step(1);
      check("dec_0101", disp, 16'h0101);
      step(4);
      check("dec_0100", disp, 16'h0100);
      step(4);
      check("dec_0059", disp, 16'h0059);

      // min_tens borrow
      do_load(16'h1000);
      pulse(1'b1, 1'b0);
      step(4);
      check("dec_0959", disp, 16'h0959);

      // load + pause in RUN: load wins, back to IDLE and stays put
      load = 1'b1; load_value = 16'h0030; pause = 1'b1;
      @(negedge clk);
      load = 1'b0; pause = 1'b0;
      check("ldpause_digits", disp, 16'h0030);
      check("ldpause_running", {15'd0, running}, 16'd0);
      step(8);
      check("idle_hold", disp, 16'h0030);

      // pause / resume keeps the prescaler count
      do_load(16'h0005);
      pulse(1'b1, 1'b0);
      step(2);
      pulse(1'b0, 1'b1);
      check("paused_running", {15'd0, running}, 16'd0);
      step(10);
      check("paused_digits", disp, 16'h0005);
      pulse(1'b1, 1'b0);
      check("resume_running", {15'd0, running}, 16'd1);
      step(1);
      check("resume_hold", disp, 16'h0005);
      step(1);
      check("resume_dec", disp, 16'h0004);
      pulse(1'b1, 1'b1);
      check("run_both_pause", {15'd0, running}, 16'd0);
      pulse(1'b1, 1'b1);
      check("paused_both_start", {15'd0, running}, 16'd1);

      // pause in the tick cycle suppresses that decrement
      do_load(16'h0002);
      pulse(1'b1, 1'b0);
      step(3);
      pulse(1'b0, 1'b1);
      check("tick_pause_digits", disp, 16'h0002);
      pulse(1'b1, 1'b0);
      check("tick_resume_hold", disp, 16'h0002);
      step(1);
      check("tick_resume_dec", disp, 16'h0001);

      // expiry
      do_load(16'h0001);
      pulse(1'b1, 1'b0);
      step(3);
      check("exp_pre", disp, 16'h0001);
      step(1);
      check("exp_digits", disp, 16'h0000);
      check("exp_flag", {15'd0, expired}, 16'd1);
      check("exp_running", {15'd0, running}, 16'd0);
      pulse(1'b1, 1'b0);
      check("exp_start_ignored", {14'd0, running, expired}, 16'd1);
      do_load(16'h0030);
      check("exp_clear_flag", {15'd0, expired}, 16'd0);
      check("exp_clear_digits", disp, 16'h0030);

      // clamping and zero start
      do_load(16'hFF9F);
      check("clamp_ff9f", disp, 16'h9959);
      do_load(16'h7F9A);
      check("clamp_7f9a", disp, 16'h7959);
      do_load(16'h0000);
      pulse(1'b1, 1'b0);
      step(5);
      check("zero_start", {14'd0, running, expired}, 16'd0);
      check("zero_digits", disp, 16'h0000);

      // reset during RUN
      do_load(16'h0102);
      pulse(1'b1, 1'b0);
      step(2);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("run_reset_digits", disp, 16'h0000);
      check("run_reset_flags", {14'd0, running, expired}, 16'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
